// File: rtl/alu_sequencer.sv
// alu_sequencer: queues ALU commands in a small FIFO, issues them one at a time to an
// external combinational ALU through registered operand ports, and returns each
// result on a valid/ready response channel. Commands can chain on the last
// delivered result. Opcodes 1010..1111 are rejected with an error response.
module alu_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_r,
    input  logic [31:0] cmd_rw,
    input  logic        cmd_chain,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_in_r,
    output logic [31:0] alu_in_rw,
    input  logic [31:0] alu_out,
    input  logic        alu_is_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [3:0] MaxLegalOp = 4'd9;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] r;
        logic [31:0] rw;
        logic        chain;
    } entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_t;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    state_t         state;
    logic [31:0]    last_result;
    logic           exec_err;

    logic           push;
    logic           pop;
    logic           fifo_empty;
    entry_t         head;
    logic           head_legal;
    logic [31:0]    chain_src;
    logic [31:0]    ld_rw;

    assign fifo_empty = (count == '0);
    assign cmd_ready  = (count != CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    // A pop happens whenever the FSM is about to start a new command.
    assign pop        = !fifo_empty && ((state == StIdle) || ((state == StResp) && rsp_ready));
    assign head       = mem[rd_ptr];
    assign head_legal = (head.op <= MaxLegalOp);

    // On a RESP handshake last_result updates in the same edge, so forward the
    // response being retired; error responses never replace last_result.
    assign chain_src  = ((state == StResp) && !rsp_err) ? rsp_data : last_result;
    assign ld_rw      = head.chain ? chain_src : head.rw;

    assign busy       = !fifo_empty || (state != StIdle);

    // FIFO storage: write-only array, contents are don't-care until counted in
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: cmd_op, r: cmd_r, rw: cmd_rw, chain: cmd_chain};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer FSM with registered ALU operands and response outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= StIdle;
            last_result <= '0;
            exec_err    <= 1'b0;
            alu_op      <= '0;
            alu_in_r    <= '0;
            alu_in_rw   <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_zero    <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (pop) begin
                        // Illegal opcodes leave the ALU operands untouched
                        if (head_legal) begin
                            alu_op    <= head.op;
                            alu_in_r  <= head.r;
                            alu_in_rw <= ld_rw;
                        end
                        exec_err <= !head_legal;
                        state    <= StExec;
                    end
                end
                StExec: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= exec_err;
                    rsp_data  <= exec_err ? 32'd0 : alu_out;
                    rsp_zero  <= !exec_err && alu_is_zero;
                    state     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        if (!rsp_err) begin
                            last_result <= rsp_data;
                        end
                        rsp_valid <= 1'b0;
                        if (!fifo_empty) begin
                            if (head_legal) begin
                                alu_op    <= head.op;
                                alu_in_r  <= head.r;
                                alu_in_rw <= ld_rw;
                            end
                            exec_err <= !head_legal;
                            state    <= StExec;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios with literal expectations plus a
// randomized phase, all checked against an in-order command/response model.
module tb_alu_sequencer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_r;
    logic [31:0] cmd_rw;
    logic        cmd_chain;
    logic [3:0]  alu_op;
    logic [31:0] alu_in_r;
    logic [31:0] alu_in_rw;
    logic [31:0] alu_out;
    logic        alu_is_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] r;
        logic [31:0] rw;
        logic        chain;
    } cmd_t;

    cmd_t        q[$];
    logic [31:0] m_last;
    logic [33:0] m_e;
    logic [33:0] c_e;

    always #5 clk = ~clk;

    alu_sequencer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_r       (cmd_r),
        .cmd_rw      (cmd_rw),
        .cmd_chain   (cmd_chain),
        .alu_op      (alu_op),
        .alu_in_r    (alu_in_r),
        .alu_in_rw   (alu_in_rw),
        .alu_out     (alu_out),
        .alu_is_zero (alu_is_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    // External ALU behaviour assumed by this bench
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] r,
                                           input logic [31:0] rw);
        case (op)
            4'd0:    return r + rw;
            4'd1:    return r - rw;
            4'd2:    return rw << r[4:0];
            4'd3:    return rw >> r[4:0];
            4'd4:    return r & rw;
            4'd5:    return r | rw;
            4'd6:    return r ^ rw;
            4'd7:    return ~(r | rw);
            4'd8:    return r;
            4'd9:    return rw;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_out     = alu_fn(alu_op, alu_in_r, alu_in_rw);
        alu_is_zero = (alu_out == 32'd0);
    end

    // Expected {err, zero, data} for a command given the last delivered result
    function automatic logic [33:0] model_rsp(input cmd_t c, input logic [31:0] last);
        logic [31:0] res;
        if (c.op > 4'd9) return {1'b1, 1'b0, 32'd0};
        res = alu_fn(c.op, c.r, c.chain ? last : c.rw);
        return {1'b0, (res == 32'd0), res};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: accepted commands queue up; each handshake retires the head in order
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_last = 32'd0;
        end else begin
            if (rsp_valid && rsp_ready && (q.size() > 0)) begin
                m_e = model_rsp(q[0], m_last);
                if (!m_e[33]) m_last = m_e[31:0];
                void'(q.pop_front());
            end
            if (cmd_valid && cmd_ready) begin
                cmd_t c;
                c.op    = cmd_op;
                c.r     = cmd_r;
                c.rw    = cmd_rw;
                c.chain = cmd_chain;
                q.push_back(c);
            end
        end
    end

    // Compare process: busy tracks outstanding work, responses match the model head
    always @(negedge clk) begin
        if (reset_n) begin
            chk("busy", {31'd0, busy}, {31'd0, (q.size() != 0)});
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_valid_without_cmd", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    c_e = model_rsp(q[0], m_last);
                    chk("rsp_data", rsp_data, c_e[31:0]);
                    chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, c_e[32]});
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, c_e[33]});
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] r, input logic [31:0] rw,
                        input logic ch);
        int k = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_r     = r;
        cmd_rw    = rw;
        cmd_chain = ch;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Waits for a response (rsp_ready assumed high) and returns it after the handshake
    task automatic wait_rsp(output logic [31:0] d, output logic z, output logic e);
        int k = 0;
        @(negedge clk);
        while (!rsp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!rsp_valid) chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
        d = rsp_data;
        z = rsp_zero;
        e = rsp_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        z;
        logic        e;
        logic        acc [6];
        logic [31:0] bp_data [8];
        int          bp_cyc [8];
        int          n_bp;
        int          n_acc;
        int          n_post;
        int          k;

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_r     = '0;
        cmd_rw    = '0;
        cmd_chain = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_alu_in_r", alu_in_r, 32'd0);
        reset_n = 1'b1;

        // ADD with latency checks
        send(4'd0, 32'd5, 32'd7, 1'b0);
        @(negedge clk);
        chk("add_lat_valid_t1", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("add_alu_op", {28'd0, alu_op}, 32'd0);
        chk("add_alu_in_r", alu_in_r, 32'd5);
        chk("add_alu_in_rw", alu_in_rw, 32'd7);
        chk("add_lat_valid_t2", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("add_lat_valid_t3", {31'd0, rsp_valid}, 32'd1);
        chk("add_data", rsp_data, 32'd12);
        chk("add_zero", {31'd0, rsp_zero}, 32'd0);
        chk("add_err", {31'd0, rsp_err}, 32'd0);
        @(posedge clk);
        #1;

        // SUB to zero
        send(4'd1, 32'd9, 32'd9, 1'b0);
        wait_rsp(d, z, e);
        chk("sub_data", d, 32'd0);
        chk("sub_zero", {31'd0, z}, 32'd1);

        // Chaining
        send(4'd0, 32'd3, 32'd4, 1'b0);
        wait_rsp(d, z, e);
        chk("chain_first", d, 32'd7);
        send(4'd2, 32'd2, 32'd99, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("chain_alu_in_rw", alu_in_rw, 32'd7);
        wait_rsp(d, z, e);
        chk("chain_data", d, 32'd28);

        // Illegal opcode leaves ALU operands and last_result alone
        send(4'd0, 32'd3, 32'd4, 1'b0);
        wait_rsp(d, z, e);
        chk("illegal_pre", d, 32'd7);
        send(4'd12, 32'd11, 32'd22, 1'b0);
        wait_rsp(d, z, e);
        chk("illegal_err", {31'd0, e}, 32'd1);
        chk("illegal_data", d, 32'd0);
        chk("illegal_zero", {31'd0, z}, 32'd0);
        chk("illegal_alu_op_held", {28'd0, alu_op}, 32'd0);
        chk("illegal_alu_in_r_held", alu_in_r, 32'd3);
        send(4'd0, 32'd1, 32'd0, 1'b1);
        wait_rsp(d, z, e);
        chk("illegal_post_chain", d, 32'd8);

        // Backpressure: 6 offered back-to-back, 5 fit
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acc[i]    = cmd_ready;
            cmd_valid = 1'b1;
            cmd_op    = 4'd0;
            cmd_r     = 32'(i + 1);
            cmd_rw    = 32'(10 * i);
            cmd_chain = 1'b0;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 5; i++) if (acc[i]) n_acc++;
        chk("bp_accepted", 32'(n_acc), 32'd5);
        chk("bp_ready_6th", {31'd0, acc[5]}, 32'd0);
        chk("bp_ready_full", {31'd0, cmd_ready}, 32'd0);
        rsp_ready = 1'b1;
        n_bp = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid && n_bp < 8) begin
                bp_data[n_bp] = rsp_data;
                bp_cyc[n_bp]  = c;
                n_bp++;
            end
            @(negedge clk);
        end
        chk("bp_rsp_count", 32'(n_bp), 32'd5);
        for (int j = 0; j < 5 && j < n_bp; j++) begin
            chk("bp_rsp_data", bp_data[j], 32'(11 * j + 1));
            if (j > 0) chk("bp_rsp_spacing", 32'(bp_cyc[j] - bp_cyc[j-1]), 32'd2);
        end

        // Reset with one response pending and two queued
        rsp_ready = 1'b0;
        send(4'd0, 32'd5, 32'd5, 1'b0);
        send(4'd0, 32'd1, 32'd2, 1'b0);
        send(4'd0, 32'd3, 32'd4, 1'b0);
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_pre_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_alu_in_r", alu_in_r, 32'd0);
        chk("rst_alu_in_rw", alu_in_rw, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        n_post = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) n_post++;
        end
        chk("rst_no_rsp_after", 32'(n_post), 32'd0);
        send(4'd0, 32'd1, 32'd77, 1'b1);
        wait_rsp(d, z, e);
        chk("rst_chain_from_zero", d, 32'd1);

        // Randomized traffic checked by the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
            cmd_rw    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            cmd_r     = ($urandom_range(0, 3) == 0) ? cmd_rw : 32'($urandom_range(0, 40));
            cmd_chain = ($urandom_range(0, 2) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drain_busy", {31'd0, busy}, 32'd0);
        chk("drain_model_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command FIFO not full.
REQ-006 SHALL have port cmd_op  input  4  ALU opcode (0000..1001 legal).
REQ-007 SHALL have port cmd_r  input  32  operand for ALU in_r.
REQ-008 SHALL have port cmd_rw  input  32  operand for ALU in_rw.
REQ-009 SHALL have port cmd_chain  input  1  use last delivered result as the in_rw operand instead of cmd_rw.
REQ-010 SHALL have ports alu_op  output  4, alu_in_r  output  32, alu_in_rw  output  32; all registered, driving the external ALU.
REQ-011 SHALL have ports alu_out  input  32, alu_is_zero  input  1; the ALU's combinational result.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-014 SHALL have ports rsp_data  output  32, rsp_zero  output  1, rsp_err  output  1  (illegal opcode).
REQ-015 SHALL have port busy  output  1  high when FIFO non-empty or state != IDLE.

Function
REQ-016 SHALL buffer commands {op, r, rw, chain} in a DEPTH-entry FIFO; push when cmd_valid && cmd_ready; cmd_ready = (count != DEPTH), combinational from count.
REQ-017 SHALL allow simultaneous push and pop in one cycle when not full; count unchanged; pointers wrap modulo DEPTH.
REQ-018 SHALL implement states IDLE, EXEC, RESP.
REQ-019 IDLE: if FIFO non-empty, pop head, load alu_op/alu_in_r/alu_in_rw, go EXEC; else stay.
REQ-020 alu_in_rw SHALL be loaded with last_result when the popped chain bit is 1, else with the popped rw.
REQ-021 EXEC (exactly one cycle): capture alu_out -> rsp_data and alu_is_zero -> rsp_zero, set rsp_valid=1, rsp_err=0, go RESP.
REQ-022 Opcodes 1010..1111 SHALL not be forwarded to the ALU (alu_* registers hold their previous values); in EXEC set rsp_data=0, rsp_zero=0, rsp_err=1 at the same latency.
REQ-023 RESP: hold rsp_valid, rsp_data, rsp_zero, rsp_err stable until rsp_valid && rsp_ready.
REQ-024 On RESP handshake: if rsp_err=0, last_result <= rsp_data; if FIFO non-empty, pop and load alu_* (per REQ-020, using the just-updated last_result) and go EXEC; else clear rsp_valid and go IDLE.
REQ-025 On direct RESP->EXEC, rsp_valid SHALL drop for the EXEC cycle.
REQ-026 Latency: command pushed into an empty FIFO at edge t0 with state IDLE -> alu_* valid after t0+1 -> rsp_valid high after t0+2.
REQ-027 Throughput with rsp_ready held high: one response per 2 cycles.
REQ-028 Responses SHALL be delivered in command order; none dropped or duplicated.
REQ-029 last_result SHALL be unchanged by error responses.

Reset
REQ-030 reset_n low SHALL immediately clear FIFO pointers/count, state=IDLE, last_result=0, alu_op=0, alu_in_r=0, alu_in_rw=0, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0, busy=0; cmd_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard the in-flight command and all queued commands without producing a response.

Verification
REQ-032 ADD: op=0000 r=5 rw=7 chain=0, rsp_ready=1 -> rsp_data=12, rsp_zero=0, rsp_err=0, rsp_valid two edges after accept.
REQ-033 SUB to zero: op=0001 r=9 rw=9 -> rsp_data=0, rsp_zero=1.
REQ-034 Chain: op=0000 r=3 rw=4 -> 7; then op=0010 r=2 chain=1 -> alu_in_rw=7, rsp_data=28.
REQ-035 Backpressure (DEPTH=4): rsp_ready=0, offer 6 commands back-to-back -> 5 accepted (1 in RESP + 4 queued), cmd_ready=0 on the 6th; raise rsp_ready -> 5 responses in order, 2 cycles apart.
REQ-036 Illegal op: after a result of 7, op=1100 -> rsp_err=1, rsp_data=0; next op=0000 r=1 chain=1 -> rsp_data=8.
REQ-037 Reset while rsp_valid=1 with 2 commands queued -> all outputs zero, cmd_ready=1, busy=0; no responses after release; subsequent chained ADD r=1 -> rsp_data=1.
